// File: rtl/lstm_y_stream_packer.sv
// Buffers LSTM y_out samples in a first-word-fall-through FIFO and streams them out with tlast every frame_len samples.
// One cycle from y_in_valid to m_tvalid; no upstream backpressure, so samples arriving while full (with no pop) are dropped and counted.
module lstm_y_stream_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic                  y_in_valid,
    input  logic [15:0]           frame_len,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CNT_WIDTH-1:0]  level,
    output logic [15:0]           overflow_count,
    input  logic                  overflow_clear
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic [15:0]          fcnt_q, fcnt_d;
    logic [15:0]          flen_q, flen_d;
    logic [15:0]          ovf_q, ovf_d;

    logic        empty, full, pop, push, drop, last_flag;
    logic [15:0] eff_len;

    assign empty = (level_q == '0);
    assign full  = (level_q == CNT_WIDTH'(DEPTH));
    assign pop   = !empty && m_tready;
    assign push  = y_in_valid && (!full || pop);
    assign drop  = y_in_valid && full && !pop;

    // A new frame takes its length from frame_len on the same cycle; later samples use the latched copy.
    always_comb begin
        eff_len = 16'd1;
        if (fcnt_q == 16'd0) begin
            if (frame_len != 16'd0) eff_len = frame_len;
        end else begin
            if (flen_q != 16'd0) eff_len = flen_q;
        end
    end

    assign last_flag = (fcnt_q == eff_len - 16'd1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        fcnt_d   = fcnt_q;
        flen_d   = flen_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            fcnt_d   = last_flag ? 16'd0 : fcnt_q + 16'd1;
            if (fcnt_q == 16'd0) flen_d = frame_len;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + CNT_WIDTH'(1);
        else if (!push && pop) level_d = level_q - CNT_WIDTH'(1);
        if (overflow_clear)                   ovf_d = 16'd0;
        else if (drop && ovf_q != 16'hFFFF)   ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            fcnt_q   <= '0;
            flen_q   <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            fcnt_q   <= fcnt_d;
            flen_q   <= flen_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= {last_flag, y_in};
    end

    // Head entry is masked while empty so stale storage never reaches the stream after reset.
    assign m_tvalid       = !empty;
    assign m_tdata        = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_tlast        = !empty && mem_q[rd_ptr_q][DATA_WIDTH];
    assign level          = level_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_lstm_y_stream_packer.sv
// Randomized and directed bench for lstm_y_stream_packer against a queue-based frame model.
module tb_lstm_y_stream_packer;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] y_in = '0;
    logic          y_in_valid = 1'b0;
    logic [15:0]   frame_len = 16'd4;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [CW-1:0] level;
    logic [15:0]   overflow_count;
    logic          overflow_clear = 1'b0;

    lstm_y_stream_packer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_in_valid(y_in_valid),
        .frame_len(frame_len), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .level(level),
        .overflow_count(overflow_count), .overflow_clear(overflow_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of {last, data}; position within the current frame and its length.
    logic [DW:0] mq[$];
    int          m_pos  = 0;
    int          m_flen = 1;
    logic [15:0] m_ovf  = 0;
    bit          started = 0;
    bit          mpop, mfull, mlast;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pos   = 0;
            m_flen  = 1;
            m_ovf   = 0;
            started = 1;
        end else if (started) begin
            mpop  = (mq.size() != 0) && m_tready;
            mfull = (mq.size() == DEPTH);
            if (mpop) void'(mq.pop_front());
            if (y_in_valid && (!mfull || mpop)) begin
                if (m_pos == 0) m_flen = (frame_len == 0) ? 1 : int'(frame_len);
                m_pos = m_pos + 1;
                mlast = (m_pos == m_flen);
                if (mlast) m_pos = 0;
                mq.push_back({mlast, y_in});
            end
            if (overflow_clear) m_ovf = 0;
            else if (y_in_valid && mfull && !mpop && m_ovf != 16'hFFFF) m_ovf = m_ovf + 1;
        end
    end

    // Per-cycle compare, AXI stall stability, and capture of delivered beats.
    logic [DW:0] beats[$];
    bit          stall_prev = 0;
    logic [DW:0] prev_beat;

    always @(negedge clk) begin
        if (started) begin
            chk("tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("ovf_count", 32'(overflow_count), 32'(m_ovf));
            if (mq.size() != 0) begin
                chk("tdata", 32'(m_tdata), 32'(mq[0][DW-1:0]));
                chk("tlast", 32'(m_tlast), 32'(mq[0][DW]));
            end
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_tvalid", 32'(m_tvalid), 32'd1);
                    chk("stall_hold", 32'({m_tlast, m_tdata}), 32'(prev_beat));
                end
                stall_prev = m_tvalid && !m_tready;
                prev_beat  = {m_tlast, m_tdata};
                if (m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        y_in       = d;
        y_in_valid = 1'b1;
        tick();
        y_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Checks beat count, data base+i, and tlast exactly on every period-th beat.
    task automatic chk_frames(input string name, input int n, input int period, input int base);
        int errs;
        errs = 0;
        chk({name, "_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < beats.size() && i < n; i++) begin
            if (beats[i][DW-1:0] !== DW'(base + i)) errs++;
            if (beats[i][DW] !== ((i % period) == period - 1)) errs++;
        end
        chk({name, "_pattern_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int sent, cyc, errs;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow_count), 32'd0);

        // Basic frame: first beat visible one cycle after the first push
        frame_len = 16'd4;
        m_tready  = 1'b1;
        beats.delete();
        push(16'd1);
        chk("first_beat_valid", 32'(m_tvalid), 32'd1);
        chk("first_beat_data", 32'(m_tdata), 32'd1);
        for (int i = 2; i <= 8; i++) push(DW'(i));
        repeat (4) tick();
        chk_frames("basic", 8, 4, 1);

        // Overflow: 20 pushes into a stalled 16-deep FIFO
        m_tready = 1'b0;
        for (int i = 1; i <= 20; i++) push(DW'(16'h100 + i));
        tick();
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_count4", 32'(overflow_count), 32'd4);
        beats.delete();
        m_tready = 1'b1;
        repeat (20) tick();
        errs = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i][DW-1:0] !== DW'(16'h101 + i)) errs++;
        chk("ovf_drain_count", 32'(beats.size()), 32'd16);
        chk("ovf_drain_order", 32'(errs), 32'd0);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow_count), 32'd0);

        // Full with simultaneous push and pop
        do_reset();
        frame_len = 16'd4;
        m_tready  = 1'b0;
        beats.delete();
        for (int i = 0; i < 16; i++) push(DW'(16'h300 + i));
        m_tready = 1'b1;
        for (int i = 16; i < 26; i++) push(DW'(16'h300 + i));
        chk("fullpop_level", 32'(level), 32'd16);
        chk("fullpop_ovf", 32'(overflow_count), 32'd0);
        repeat (20) tick();
        chk_frames("fullpop", 26, 4, 16'h300);

        // Random backpressure, frame_len 7, sparse pushes so the FIFO never fills
        do_reset();
        frame_len = 16'd7;
        beats.delete();
        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 5000) begin
            m_tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) begin
                y_in       = DW'(16'h200 + sent);
                y_in_valid = 1'b1;
                sent++;
            end else begin
                y_in       = DW'($urandom);
                y_in_valid = 1'b0;
            end
            frame_len = ($urandom_range(0, 3) == 0) ? 16'd7 : frame_len;
            tick();
            cyc++;
        end
        y_in_valid = 1'b0;
        chk("bp_sent", 32'(sent), 32'd100);
        chk("bp_no_drop", 32'(overflow_count), 32'd0);
        m_tready = 1'b1;
        repeat (24) tick();
        chk_frames("backpressure", 100, 7, 16'h200);

        // frame_len 0 behaves as 1
        do_reset();
        frame_len = 16'd0;
        beats.delete();
        for (int i = 0; i < 5; i++) push(DW'(16'h400 + i));
        repeat (4) tick();
        chk_frames("flen0", 5, 1, 16'h400);

        // frame_len changed mid-frame takes effect on the next frame
        do_reset();
        frame_len = 16'd5;
        beats.delete();
        push(16'h500);
        push(16'h501);
        frame_len = 16'd3;
        for (int i = 2; i < 8; i++) push(DW'(16'h500 + i));
        repeat (4) tick();
        errs = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i][DW] !== (i == 4 || i == 7)) errs++;
        chk("flen_change_count", 32'(beats.size()), 32'd8);
        chk("flen_change_lasts", 32'(errs), 32'd0);

        // Reset with 6 entries queued mid-frame; push during reset is ignored
        frame_len = 16'd4;
        m_tready  = 1'b0;
        for (int i = 0; i < 6; i++) push(DW'(16'h600 + i));
        chk("midrst_level6", 32'(level), 32'd6);
        y_in       = 16'hDEAD;
        y_in_valid = 1'b1;
        do_reset();
        y_in_valid = 1'b0;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        beats.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(16'h700 + i));
        repeat (4) tick();
        chk_frames("midrst_frame", 4, 4, 16'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lstm_y_stream_packer.md
# lstm_y_stream_packer

Downstream stage of the AXI4-Lite LSTM layer stack. Captures each 16-bit `y_out` sample qualified by `y_out_valid` into a small FIFO and presents the samples as an AXI4-Stream master. `m_tlast` marks frame boundaries every `frame_len` samples, so a DMA engine can move inference results without per-sample register reads. Samples that arrive while the FIFO is full are dropped and counted.

## Interface

Parameters:
- `DATA_WIDTH`, 16: sample width; matches the LSTM datapath width.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `CNT_WIDTH`, `$clog2(DEPTH)+1` (localparam): width of `level`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `y_in`  in  DATA_WIDTH  sample from the LSTM stack (`y_out`).
- `y_in_valid`  in  1  single-cycle strobe; one sample per high cycle; no backpressure exists upstream.
- `frame_len`  in  16  samples per frame; 0 is treated as 1.
- `m_tdata`  out  DATA_WIDTH  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready from the consumer.
- `m_tlast`  out  1  last beat of a frame.
- `level`  out  CNT_WIDTH  current FIFO occupancy (0..DEPTH).
- `overflow_count`  out  16  number of dropped samples; saturates at 0xFFFF.
- `overflow_clear`  in  1  synchronous clear of `overflow_count`.

## Operation

- **Storage.** DEPTH entries, each `{last_flag, data}` (DATA_WIDTH+1 bits). Write and read pointers are `$clog2(DEPTH)` bits and wrap naturally. An occupancy counter drives `level`, `full` (level == DEPTH) and `empty` (level == 0).
- **Push.** Accepted when `y_in_valid` is high and either the FIFO is not full or a pop occurs in the same cycle.
- **Pop.** Occurs when `m_tvalid && m_tready`.
- **Simultaneous push and pop.** `level` is unchanged and both pointers advance. This applies when full as well; no drop occurs in that case.
- **Overflow.** `y_in_valid` while full with no pop drops the sample. FIFO contents, pointers and the frame counter are unchanged. `overflow_count` increments and saturates at 0xFFFF.
- **overflow_clear vs. drop.** If both occur in the same cycle, `overflow_clear` wins and the count becomes 0.
- **Frame tagging (write side).**
  - Frame counter `fcnt` (16 bits) counts accepted samples only.
  - `frame_len` is latched into `flen_q` when an accepted push has `fcnt == 0`. Changes to `frame_len` mid-frame take effect at the next frame.
  - The effective length of the frame being started is `max(frame_len, 1)`, evaluated on that same cycle.
  - `last_flag = (fcnt == eff_len - 1)`. When `last_flag` is set, `fcnt` returns to 0; otherwise it increments.
- **Output.** First-word-fall-through. `m_tdata`/`m_tlast` are driven from the head entry and `m_tvalid = !empty`. While `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` hold stable, as AXI4-Stream requires.
- **Reset.** Discards all contents, including mid-frame and mid-transfer data. Reset values:
  - `m_tvalid` 0
  - `m_tlast` 0
  - `m_tdata` 0
  - `level` 0
  - `overflow_count` 0
  - pointers, `fcnt` and `flen_q` 0

  A `y_in_valid` during the reset cycle is ignored.

## Timing

- Push at rising edge N → `m_tvalid` high and `level` updated in cycle N+1. Latency from `y_in_valid` to stream output is 1 cycle.
- Sustained throughput is one sample per cycle in each direction.
- `m_tvalid` depends only on registered state. No combinational path exists from `m_tready` or `y_in_valid` to any output.
- `level` and `overflow_count` are registered and reflect events of the previous cycle.
- First cycle after reset deasserts: the block accepts pushes.

## Test plan

- **Basic frame.** `frame_len`=4, push 0x0001..0x0008 on consecutive cycles, `m_tready`=1.
  - Expect 8 beats, data in order.
  - `m_tlast` on 0x0004 and 0x0008.
  - First beat 1 cycle after first push.
- **Overflow.** `DEPTH`=16, `m_tready`=0, push 20 samples.
  - `level` = 16, `overflow_count` = 4.
  - After `m_tready`=1, exactly samples 1..16 are emitted.
  - `overflow_clear` pulse → `overflow_count` = 0.
- **Full with simultaneous pop.** Fill to 16, then push and pop in the same cycle for 10 cycles.
  - `level` stays 16, `overflow_count` stays 0.
  - Output order is preserved.
- **Backpressure.** Random `m_tready` at 50% while pushing 100 samples with `frame_len`=7.
  - `m_tdata`/`m_tlast` are stable while stalled.
  - `tlast` appears on every 7th sample; no loss, since `level` never reaches 16.
- **Frame length edge cases.**
  - `frame_len`=0 → `tlast` on every beat.
  - Change `frame_len` from 5 to 3 after the 2nd sample of a frame → that frame still ends at sample 5; the next frame ends at sample 3.
- **Reset mid-operation.** Reset with 6 entries queued mid-frame.
  - Next cycle: `m_tvalid`=0, `level`=0.
  - Subsequent pushes start a fresh frame with `fcnt`=0.
